// File: rtl/pushbutton_debouncer_pkg.sv
// Shared types and constants for the pushbutton debouncer.
// Optional feature macro: PUSHBUTTON_DEBOUNCER_PULSE_EN (see pushbutton_debouncer.sv).
package pushbutton_debouncer_pkg;

    // Per-channel filter state; the two STABLE states carry the accepted level.
    typedef enum logic [1:0] {
        REL_STABLE = 2'b00,
        PRESS_WAIT = 2'b01,
        PRS_STABLE = 2'b10,
        REL_WAIT   = 2'b11
    } db_state_t;

    // Buttons are active-low, so the idle (released) level is 1.
    localparam logic RELEASED_LEVEL = 1'b1;

    // Debounced level reported while the filter sits in a given state.
    function automatic logic level_of_state(input db_state_t st);
        return (st == REL_STABLE || st == PRESS_WAIT) ? RELEASED_LEVEL : ~RELEASED_LEVEL;
    endfunction

endpackage

// File: rtl/pushbutton_debounce_channel.sv
// One button channel: 2-flop synchroniser, 4-state filter FSM and a
// saturating stability counter. key_out comes straight from a register.
module pushbutton_debounce_channel
    import pushbutton_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic key_in,
    output logic key_out
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    logic                 r_sync1;
    logic                 r_sync2;
    db_state_t            r_state;
    logic [CNT_WIDTH-1:0] r_cnt;
    logic                 r_key_out;

    db_state_t            w_state_next;
    logic [CNT_WIDTH-1:0] w_cnt_next;

    // Bring the asynchronous button level into the clk domain; idle is released.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= RELEASED_LEVEL;
            r_sync2 <= RELEASED_LEVEL;
        end else begin
            r_sync1 <= key_in;
            r_sync2 <= r_sync1;
        end
    end

    // Filter state, counter and the registered debounced level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= REL_STABLE;
            r_cnt     <= '0;
            r_key_out <= RELEASED_LEVEL;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_key_out <= level_of_state(w_state_next);
        end
    end

    // Next-state logic: any reversal during a WAIT restarts from zero; the
    // counter stops at CNT_LAST, the cycle on which the new level is accepted.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        unique case (r_state)
            REL_STABLE: begin
                if (r_sync2 != RELEASED_LEVEL) begin
                    w_state_next = PRESS_WAIT;
                    w_cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (r_sync2 == RELEASED_LEVEL) begin
                    w_state_next = REL_STABLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = PRS_STABLE;
                end else begin
                    w_cnt_next = r_cnt + CNT_WIDTH'(1);
                end
            end
            PRS_STABLE: begin
                if (r_sync2 == RELEASED_LEVEL) begin
                    w_state_next = REL_WAIT;
                    w_cnt_next   = '0;
                end
            end
            REL_WAIT: begin
                if (r_sync2 != RELEASED_LEVEL) begin
                    w_state_next = PRS_STABLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_next = REL_STABLE;
                end else begin
                    w_cnt_next = r_cnt + CNT_WIDTH'(1);
                end
            end
            default: begin
                w_state_next = REL_STABLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign key_out = r_key_out;

endmodule

// File: rtl/pushbutton_debouncer.sv
// Debouncer for NUM_BUTTONS active-low pushbuttons feeding a PIO in_port.
// Define PUSHBUTTON_DEBOUNCER_PULSE_EN to add the press_pulse output.
module pushbutton_debouncer
    import pushbutton_debouncer_pkg::*;
#(
    parameter int NUM_BUTTONS     = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic [NUM_BUTTONS-1:0] key_in,
    output logic [NUM_BUTTONS-1:0] key_out
`ifdef PUSHBUTTON_DEBOUNCER_PULSE_EN
    ,
    output logic [NUM_BUTTONS-1:0] press_pulse
`endif
);

    logic [NUM_BUTTONS-1:0] w_key_out;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BUTTONS; gi++) begin : g_channel
            pushbutton_debounce_channel #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .CNT_WIDTH      (CNT_WIDTH)
            ) u_channel (
                .clk    (clk),
                .reset_n(reset_n),
                .key_in (key_in[gi]),
                .key_out(w_key_out[gi])
            );
        end
    endgenerate

    assign key_out = w_key_out;

`ifdef PUSHBUTTON_DEBOUNCER_PULSE_EN
    logic [NUM_BUTTONS-1:0] r_key_prev;
    logic [NUM_BUTTONS-1:0] r_press_pulse;

    // Register the released->pressed transition of key_out; releases give no pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key_prev    <= {NUM_BUTTONS{RELEASED_LEVEL}};
            r_press_pulse <= '0;
        end else begin
            r_key_prev    <= w_key_out;
            r_press_pulse <= r_key_prev & ~w_key_out;
        end
    end

    assign press_pulse = r_press_pulse;
`endif

endmodule
